// File: rtl/seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: one stage enable per cycle,
// CC write gating, data-memory handshake and status code. Define SEQ_CTRL_PERF_EN for perf counters.
module seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             wb_en,
    output logic             pc_we,
    output logic             cc_we,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // state   | meaning
    // IDLE    | out of reset, waiting for start
    // FETCH   | fetch_en; icode/imem_error sampled, halt/error checks
    // DECODE  | decode_en
    // EXECUTE | execute_en; cc_we for OPq
    // MEMORY  | mem_req for memory icodes, held until mem_ready
    // WRBACK  | wb_en
    // PCUPD   | pc_we; instruction retires
    // HALTED  | stopped with stat frozen, waiting for start
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEMORY  = 3'd4;
    localparam logic [2:0] S_WRBACK  = 3'd5;
    localparam logic [2:0] S_PCUPD   = 3'd6;
    localparam logic [2:0] S_HALTED  = 3'd7;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_OPQ  = 4'h6;
    localparam logic [3:0] IC_MAX  = 4'hB;

    logic [2:0] state_q, state_d;
    logic [1:0] stat_q, stat_d;
    logic [3:0] icode_q, icode_d;
    logic       is_mem;
    logic       is_wr;

    always_comb begin
        is_mem = 1'b0;
        is_wr  = 1'b0;
        case (icode_q)
            4'h4, 4'h8, 4'hA: begin
                is_mem = 1'b1;
                is_wr  = 1'b1;
            end
            4'h5, 4'h9, 4'hB: is_mem = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    stat_d  = STAT_AOK;
                end
            end
            S_FETCH: begin
                icode_d = icode;
                // Address error outranks any judgement of the (possibly garbage) opcode.
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else if (icode > IC_MAX) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALTED;
                end else if (icode == IC_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem) begin
                    state_d = S_WRBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_WRBACK;
                    end
                end
            end
            S_WRBACK: state_d = S_PCUPD;
            S_PCUPD:  state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= 4'h0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
        end
    end

    assign fetch_en   = (state_q == S_FETCH);
    assign decode_en  = (state_q == S_DECODE);
    assign execute_en = (state_q == S_EXECUTE);
    assign wb_en      = (state_q == S_WRBACK);
    assign pc_we      = (state_q == S_PCUPD);
    assign cc_we      = (state_q == S_EXECUTE) && (icode_q == IC_OPQ);
    assign mem_req    = (state_q == S_MEMORY) && is_mem;
    assign mem_wr     = (state_q == S_MEMORY) && is_mem && is_wr;
    assign stat       = stat_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted     = (state_q == S_HALTED);

`ifdef SEQ_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             launch;
    logic             retire;

    assign launch = start && ((state_q == S_IDLE) || (state_q == S_HALTED));
    assign retire = (state_q == S_PCUPD);

    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (launch) begin
            cycle_d = '0;
            instr_d = '0;
        end else begin
            if (busy)   cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (retire) instr_d = instr_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule
